roteador_rr: RTL and testbench



---
 rtl/roteador_rr.sv | 119 +++++++++++
 tb/tb_roteador_rr.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/roteador_rr.sv
// roteador_rr: NCH-channel valid/ready router (fixed select or round-robin) into one registered output.
// Optional per-channel saturating grant counters when ROTEADOR_CONTADOR_EN is defined.
module roteador_rr #(
   parameter  int NBITS = 4,
   parameter  int NCH   = 4,
   localparam int SELW  = $clog2(NCH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NCH*NBITS-1:0]   in_data,
   input  logic [NCH-1:0]         in_valid,
   output logic [NCH-1:0]         in_ready,
   input  logic                   mode,
   input  logic [SELW-1:0]        sel,
   output logic [NBITS-1:0]       out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [SELW-1:0]        out_ch
`ifdef ROTEADOR_CONTADOR_EN
   ,
   output logic [NCH*8-1:0]       grant_count
`endif
);

   typedef enum logic {S_EMPTY, S_FULL} state_t;

   state_t            r_state;
   logic [NBITS-1:0]  r_data;
   logic [SELW-1:0]   r_ch;
   logic [SELW-1:0]   r_last;

   logic              w_free;
   logic              w_grant_vld;
   logic [SELW-1:0]   w_grant_idx;
   logic [NBITS-1:0]  w_grant_data;

   assign out_valid = (r_state == S_FULL);
   assign out_data  = r_data;
   assign out_ch    = r_ch;
   assign w_free    = !out_valid || out_ready;

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      int v_best;
      int v_dist;
      w_grant_vld  = 1'b0;
      w_grant_idx  = '0;
      w_grant_data = '0;
      v_best       = NCH;
      v_dist       = 0;
      if (w_free) begin
         if (!mode) begin
            for (int k = 0; k < NCH; k++) begin
               if (int'(sel) == k && in_valid[k]) begin
                  w_grant_vld = 1'b1;
                  w_grant_idx = SELW'(k);
               end
            end
         end else begin
            // Distance from the channel after last; last itself is searched last.
            for (int k = 0; k < NCH; k++) begin
               v_dist = k + NCH - 1 - int'(r_last);
               if (v_dist >= NCH) v_dist = v_dist - NCH;
               if (in_valid[k] && v_dist < v_best) begin
                  v_best      = v_dist;
                  w_grant_vld = 1'b1;
                  w_grant_idx = SELW'(k);
               end
            end
         end
      end
      for (int k = 0; k < NCH; k++) begin
         if (int'(w_grant_idx) == k) w_grant_data = in_data[k*NBITS +: NBITS];
      end
   end

   assign in_ready = NCH'(w_grant_vld) << w_grant_idx;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_EMPTY;
         r_data  <= '0;
         r_ch    <= '0;
         r_last  <= SELW'(NCH - 1);
      end else begin
         case (r_state)
            S_EMPTY: if (w_grant_vld) r_state <= S_FULL;
            S_FULL:  if (out_ready && !w_grant_vld) r_state <= S_EMPTY;
            default: r_state <= S_EMPTY;
         endcase
         if (w_grant_vld) begin
            r_data <= w_grant_data;
            r_ch   <= w_grant_idx;
            r_last <= w_grant_idx;
         end
      end
   end

`ifdef ROTEADOR_CONTADOR_EN
   logic [7:0] r_cnt [NCH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NCH; k++) r_cnt[k] <= '0;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (w_grant_vld && int'(w_grant_idx) == k && r_cnt[k] != 8'hFF)
               r_cnt[k] <= r_cnt[k] + 8'd1;
         end
      end
   end

   for (genvar gk = 0; gk < NCH; gk++) begin : g_cnt
      assign grant_count[gk*8 +: 8] = r_cnt[gk];
   end
`endif

endmodule

// File: tb/tb_roteador_rr.sv
// Randomised scoreboard bench for roteador_rr (NCH=4) plus directed bounds checks on an NCH=3 instance.
module tb_roteador_rr;
   localparam int NBITS = 4;
   localparam int NCH   = 4;
   localparam int SELW  = 2;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NCH*NBITS-1:0]  in_data;
   logic [NCH-1:0]        in_valid;
   logic [NCH-1:0]        in_ready;
   logic                  mode;
   logic [SELW-1:0]       sel;
   logic [NBITS-1:0]      out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [SELW-1:0]       out_ch;

   logic [3*NBITS-1:0]    in_data3;
   logic [2:0]            in_valid3;
   logic [2:0]            in_ready3;
   logic                  mode3;
   logic [1:0]            sel3;
   logic [NBITS-1:0]      out_data3;
   logic                  out_valid3;
   logic                  out_ready3;
   logic [1:0]            out_ch3;
`ifdef ROTEADOR_CONTADOR_EN
   logic [NCH*8-1:0]      grant_count;
   logic [3*8-1:0]        grant_count3;
`endif

   always #5 clk = ~clk;

   roteador_rr #(.NBITS(NBITS), .NCH(NCH)) u_dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_ch(out_ch)
`ifdef ROTEADOR_CONTADOR_EN
      , .grant_count(grant_count)
`endif
   );

   roteador_rr #(.NBITS(NBITS), .NCH(3)) u_dut3 (
      .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .mode(mode3), .sel(sel3), .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
      .out_ch(out_ch3)
`ifdef ROTEADOR_CONTADOR_EN
      , .grant_count(grant_count3)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [NBITS-1:0] data;
      int               ch;
   } word_t;

   word_t sb_q[$];
   bit    m_full      = 1'b0;
   bit    m_cur_valid = 1'b0;
   int    m_last      = NCH - 1;
   int    m_cnt [NCH];

   // Reference grant decision: -1 when nothing is granted.
   function automatic int model_grant(input bit md, input int s, input logic [NCH-1:0] v);
      if (!md) begin
         if (s < NCH && ((v >> s) & NCH'(1)) != 0) return s;
         return -1;
      end
      for (int i = 1; i <= NCH; i++) begin
         int k;
         k = (m_last + i) % NCH;
         if (((v >> k) & NCH'(1)) != 0) return k;
      end
      return -1;
   endfunction

   task automatic drive_cycle(input bit md, input int s, input logic [NCH-1:0] v,
                              input logic [NCH*NBITS-1:0] d, input bit rdy);
      int    g;
      bit    free;
      word_t w;
      @(posedge clk);
      #1;
      mode      = md;
      sel       = SELW'(s);
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
      m_cur_valid = m_full;
      free = !m_full || rdy;
      g = free ? model_grant(md, s, v) : -1;
      #1;
      check("in_ready", 32'(in_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      if (g >= 0) begin
         w.data = d[g*NBITS +: NBITS];
         w.ch   = g;
         sb_q.push_back(w);
         m_full = 1'b1;
         m_last = g;
         if (m_cnt[g] < 255) m_cnt[g]++;
      end else if (free) begin
         m_full = 1'b0;
      end
   endtask

   task automatic mid_reset();
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_ch", 32'(out_ch), 32'd0);
      sb_q.delete();
      m_full      = 1'b0;
      m_cur_valid = 1'b0;
      m_last      = NCH - 1;
      foreach (m_cnt[k]) m_cnt[k] = 0;
      in_valid = '0;
      #1;
      reset = 1'b0;
   endtask

   // Monitor: compares the presented word every cycle, retires it on a transfer.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            check("out_valid", 32'(out_valid), 32'(m_cur_valid));
            if (out_valid) begin
               if (sb_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL out_word: got ch %0d data %0h expected no word", out_ch, out_data);
               end else begin
                  check("out_data", 32'(out_data), 32'(sb_q[0].data));
                  check("out_ch", 32'(out_ch), 32'(sb_q[0].ch));
                  if (out_ready) void'(sb_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      foreach (m_cnt[k]) m_cnt[k] = 0;
      reset = 1'b1;
      in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
      in_data3 = '0; in_valid3 = '0; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b0;
      #12;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_data", 32'(out_data), 32'd0);
      check("reset_out_ch", 32'(out_ch), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Fixed select of channel 2.
      drive_cycle(1'b0, 2, 4'b0100, 16'h0A00, 1'b1);

      // Round-robin: all valid, then alternating pair.
      repeat (5) drive_cycle(1'b1, 0, 4'hF, (NCH*NBITS)'($urandom), 1'b1);
      repeat (4) drive_cycle(1'b1, 0, 4'b1010, (NCH*NBITS)'($urandom), 1'b1);

      // Backpressure: hold 4'h5 while inputs churn.
      drive_cycle(1'b0, 0, 4'b0001, 16'h0005, 1'b1);
      repeat (3) drive_cycle(1'($urandom), int'($urandom_range(0, 3)), NCH'($urandom),
                             (NCH*NBITS)'($urandom), 1'b0);
      drive_cycle(1'b1, 0, 4'hF, (NCH*NBITS)'($urandom), 1'b1);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         drive_cycle(1'($urandom), int'($urandom_range(0, 3)), NCH'($urandom),
                     (NCH*NBITS)'($urandom), ($urandom_range(0, 3) != 0));
      end

      // Reset in the middle of a burst with a word held.
      repeat (3) drive_cycle(1'b1, 0, 4'hF, (NCH*NBITS)'($urandom), 1'b1);
      drive_cycle(1'b1, 0, 4'hF, (NCH*NBITS)'($urandom), 1'b0);
      mid_reset();
      drive_cycle(1'b1, 0, 4'hF, (NCH*NBITS)'($urandom), 1'b1);

      // Single channel granted every free cycle (also drives its counter to saturation).
      repeat (300) drive_cycle(1'b0, 1, 4'hF, (NCH*NBITS)'($urandom), 1'b1);
`ifdef ROTEADOR_CONTADOR_EN
      #1;
      for (int k = 0; k < NCH; k++) check("grant_count", 32'(grant_count[k*8 +: 8]), 32'(m_cnt[k]));
`endif

      repeat (2) drive_cycle(1'b0, 0, 4'h0, '0, 1'b1);
      @(negedge clk);
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      // NCH=3 instance: out-of-range select, mode change while full, wrap 2 -> 0.
      @(posedge clk); #1;
      mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b001; in_data3 = 12'h007; out_ready3 = 1'b1;
      #1 check("n3_fixed_ready", 32'(in_ready3), 32'b001);
      @(posedge clk); #1;
      check("n3_load_valid", 32'(out_valid3), 32'd1);
      check("n3_load_data", 32'(out_data3), 32'h7);
      check("n3_load_ch", 32'(out_ch3), 32'd0);
      sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 12'h321;
      #1 check("n3_sel_oob_ready", 32'(in_ready3), 32'd0);
      @(posedge clk); #1;
      check("n3_sel_oob_valid", 32'(out_valid3), 32'd0);
      sel3 = 2'd1;
      #1 check("n3_sel1_ready", 32'(in_ready3), 32'b010);
      @(posedge clk); #1;
      check("n3_sel1_data", 32'(out_data3), 32'h2);
      out_ready3 = 1'b0; mode3 = 1'b1; in_data3 = 12'h9AB;
      #1 check("n3_hold_ready", 32'(in_ready3), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("n3_hold_data", 32'(out_data3), 32'h2);
      check("n3_hold_ch", 32'(out_ch3), 32'd1);
      check("n3_hold_valid", 32'(out_valid3), 32'd1);
      out_ready3 = 1'b1;
      #1 check("n3_rr_next_ready", 32'(in_ready3), 32'b100);
      @(posedge clk); #1;
      check("n3_rr_next_data", 32'(out_data3), 32'h9);
      check("n3_rr_next_ch", 32'(out_ch3), 32'd2);
      #1 check("n3_rr_wrap_ready", 32'(in_ready3), 32'b001);
      @(posedge clk); #1;
      check("n3_rr_wrap_ch", 32'(out_ch3), 32'd0);
      check("n3_rr_wrap_data", 32'(out_data3), 32'hB);
      in_valid3 = 3'b000;
      @(posedge clk); #1;
      check("n3_drain_valid", 32'(out_valid3), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
